// File: rtl/traffic_ctrl_n.sv
// traffic_ctrl_n: N-way round-robin traffic light controller with demand latching and min/max green.
module traffic_ctrl_n #(
    parameter int N_WAYS    = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic [N_WAYS-1:0]           sense,
    output logic [3*N_WAYS-1:0]         lights,
    output logic [$clog2(N_WAYS)-1:0]   active_way,
    output logic [1:0]                  phase,
    output logic [N_WAYS-1:0]           pending
);
    localparam int AW = $clog2(N_WAYS);
    localparam logic [CNT_W:0] GMIN_C = (CNT_W+1)'(GREEN_MIN);
    localparam logic [CNT_W:0] GMAX_C = (CNT_W+1)'(GREEN_MAX);
    localparam logic [CNT_W:0] YT_C   = (CNT_W+1)'(YELLOW_T);
    localparam logic [CNT_W:0] AT_C   = (CNT_W+1)'(ALLRED_T);

    if (N_WAYS < 2 || N_WAYS > 8 || GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN ||
        YELLOW_T < 1 || ALLRED_T < 1 || (2 ** CNT_W) <= GREEN_MAX) begin : g_bad_params
        $error("traffic_ctrl_n: parameter out of range");
    end

    typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, ALLRED = 2'd2} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  timer, timer_nx;
    logic [AW-1:0]     way, way_nx, rr;
    logic [N_WAYS-1:0] pend_nx;
    logic [CNT_W:0]    t1;
    logic              others, go_y, go_r, go_g, found;
    int                idx;

    // first pending way after the current one; the current way itself is tried last
    always_comb begin
        rr = (way == AW'(N_WAYS - 1)) ? '0 : way + 1'b1;
        found = 1'b0;
        idx = 0;
        for (int k = 1; k <= N_WAYS; k++) begin
            idx = (int'(way) + k) % N_WAYS;
            if (!found && pending[idx]) begin
                rr = AW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        t1 = {1'b0, timer} + 1'b1;
        others = |(pending & ~(N_WAYS'(1) << way));
        go_y = tick && state == GREEN && t1 >= GMIN_C && others && (!sense[way] || t1 >= GMAX_C);
        go_r = tick && state == YELLOW && t1 == YT_C;
        go_g = tick && state == ALLRED && t1 == AT_C;
        state_nx = go_y ? YELLOW : go_r ? ALLRED : go_g ? GREEN : state;
        way_nx = go_g ? rr : way;
        timer_nx = (go_y || go_r || go_g) ? '0 :
                   (tick && {1'b0, timer} < GMAX_C) ? timer + 1'b1 : timer;
        pend_nx = pending;
        for (int i = 0; i < N_WAYS; i++)
            pend_nx[i] = (pending[i] | (sense[i] & !(state == GREEN && way == AW'(i))))
                         & !(go_g && rr == AW'(i));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= GREEN;
            way     <= '0;
            timer   <= '0;
            pending <= '0;
        end else begin
            state   <= state_nx;
            way     <= way_nx;
            timer   <= timer_nx;
            pending <= pend_nx;
        end
    end

    always_comb begin
        lights = '1;
        for (int i = 0; i < N_WAYS; i++)
            lights[3*i +: 3] = (way == AW'(i)) ?
                (state == GREEN ? 3'b011 : state == YELLOW ? 3'b001 : 3'b111) : 3'b111;
    end

    assign active_way = way;
    assign phase      = state;
endmodule

// File: tb/tb_traffic_ctrl_n.sv
// tb_traffic_ctrl_n: directed and randomized checks of traffic_ctrl_n against a tick-count reference model.
module tb_traffic_ctrl_n;
    localparam int N = 3, GMIN = 4, GMAX = 8, YT = 2, AT = 1;

    logic       clk = 1'b0, reset = 1'b0, tick = 1'b0;
    logic [2:0] sense = '0;
    logic [8:0] lights;
    logic [1:0] active_way, phase;
    logic [2:0] pending;

    int n_vec = 0, n_err = 0;
    int m_phase, m_way, m_el;
    logic [2:0] m_pend;
    int greens[$];
    int last_green;

    traffic_ctrl_n #(.N_WAYS(N), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT),
                     .ALLRED_T(AT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .tick(tick), .sense(sense),
        .lights(lights), .active_way(active_way), .phase(phase), .pending(pending));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] exp_lights();
        logic [8:0] l = '1;
        for (int i = 0; i < N; i++)
            if (i == m_way)
                l[3*i +: 3] = (m_phase == 0) ? 3'b011 : (m_phase == 1) ? 3'b001 : 3'b111;
        return l;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_way = 0; m_el = 0; m_pend = '0;
    endtask

    // one clock edge of the controller rules, counting ticks spent in the current phase
    task automatic model_edge(input logic [2:0] s, input logic t);
        logic [2:0] np = m_pend;
        logic [2:0] one = 3'b001;
        int e, nph, nw;
        for (int i = 0; i < N; i++)
            if (s[i] && !(m_phase == 0 && m_way == i)) np[i] = 1'b1;
        if (t) begin
            e = m_el + 1;
            nph = m_phase;
            if (m_phase == 0) begin
                if (e >= GMIN && (m_pend & ~(one << m_way)) != 0 && (!s[m_way] || e >= GMAX)) nph = 1;
            end else if (m_phase == 1) begin
                if (e == YT) nph = 2;
            end else if (e == AT) begin
                nw = (m_way + 1) % N;
                for (int k = N; k >= 1; k--)
                    if (m_pend[(m_way + k) % N]) nw = (m_way + k) % N;
                np[nw] = 1'b0;
                m_way = nw;
                nph = 0;
            end
            m_el = (nph != m_phase) ? 0 : e;
            m_phase = nph;
        end
        m_pend = np;
    endtask

    task automatic compare_all();
        check("lights", 32'(lights), 32'(exp_lights()));
        check("active_way", 32'(active_way), 32'(m_way));
        check("phase", 32'(phase), 32'(m_phase));
        check("pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic step(input logic [2:0] s, input logic t);
        sense = s;
        tick = t;
        model_edge(s, t);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_lights", 32'(lights), 32'h1fb);
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
    endtask

    initial begin
        do_reset();

        // idle
        for (int i = 0; i < 50; i++) step(3'b000, 1'b1);
        check("idle_lights", 32'(lights), 32'h1fb);
        check("idle_pending", 32'(pending), 32'h0);

        // single request from way 2
        do_reset();
        step(3'b000, 1'b1);
        step(3'b100, 1'b1);
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        check("single_yellow", 32'(phase), 32'd1);
        step(3'b000, 1'b1);
        check("single_yellow2", 32'(phase), 32'd1);
        step(3'b000, 1'b1);
        check("single_allred", 32'(phase), 32'd2);
        step(3'b000, 1'b1);
        check("single_green", 32'(phase), 32'd0);
        check("single_way", 32'(active_way), 32'd2);
        check("single_pend", 32'(pending[2]), 32'd0);

        // max green with way 0 still sensing
        do_reset();
        step(3'b011, 1'b1);
        for (int i = 0; i < 6; i++) step(3'b001, 1'b1);
        check("maxg_hold", 32'(phase), 32'd0);
        step(3'b001, 1'b1);
        check("maxg_exit", 32'(phase), 32'd1);
        for (int i = 0; i < 3; i++) step(3'b001, 1'b1);
        check("maxg_next", 32'({phase, active_way}), 32'({2'd0, 2'd1}));

        // round-robin wrap from way 2
        do_reset();
        step(3'b100, 1'b1);
        for (int i = 0; i < 40 && !(phase == 2'd0 && active_way == 2'd2); i++) step(3'b000, 1'b1);
        check("rr_reach2", 32'({phase, active_way}), 32'({2'd0, 2'd2}));
        step(3'b011, 1'b1);
        greens.delete();
        last_green = 2;
        for (int i = 0; i < 40; i++) begin
            step(3'b000, 1'b1);
            if (phase == 2'd0 && int'(active_way) != last_green) begin
                last_green = int'(active_way);
                greens.push_back(last_green);
            end
        end
        check("rr_count", 32'(greens.size() >= 2), 32'd1);
        if (greens.size() >= 2) begin
            check("rr_first", 32'(greens[0]), 32'd0);
            check("rr_second", 32'(greens[1]), 32'd1);
        end

        // tick gating during yellow
        do_reset();
        step(3'b010, 1'b1);
        for (int i = 0; i < 40 && phase != 2'd1; i++) step(3'b000, 1'b1);
        check("gate_reach", 32'(phase), 32'd1);
        for (int i = 0; i < 10; i++) step(3'b000, 1'b0);
        check("gate_frozen", 32'(phase), 32'd1);
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        check("gate_resume", 32'(phase), 32'd2);

        // reset during yellow of way 1
        do_reset();
        for (int i = 0; i < 60 && !(phase == 2'd1 && active_way == 2'd1); i++)
            step((active_way == 2'd1 && phase == 2'd0) ? 3'b100 : 3'b010, 1'b1);
        check("mid_reach", 32'({phase, active_way}), 32'({2'd1, 2'd1}));
        #2;
        do_reset();
        check("mid_phase", 32'(phase), 32'd0);
        check("mid_pending", 32'(pending), 32'd0);

        // randomized traffic with random tick gating and occasional resets
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            logic [2:0] s;
            for (int b = 0; b < 3; b++) s[b] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(s, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
